// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider: one quotient bit per clock over N cycles.
// Optional macro DIVISOR_CERO_EN: zero divisor short-circuits IDLE->DONE and flags div_cero.

module restador #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuendo,
  input  logic [W-1:0] sustraendo,
  output logic [W-1:0] diferencia,
  output logic         cout_restador
);
  logic [W:0] c;

  assign c[0] = 1'b1;

  // a - b computed as a + ~b + 1; final carry of 1 means no borrow.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic p;
    assign p             = minuendo[i] ^ ~sustraendo[i];
    assign diferencia[i] = p ^ c[i];
    assign c[i+1]        = (minuendo[i] & ~sustraendo[i]) | (c[i] & p);
  end

  assign cout_restador = c[W];
endmodule

module divisor_secuencial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo,
  output logic         busy,
  output logic         done,
  output logic         div_cero,
  output logic [1:0]   estado_dbg
);
  // Handshake: start is accepted only when the FSM is in IDLE; done pulses for
  // exactly one cycle with cociente/residuo valid, busy covers the RUN cycles.
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  coc_q, coc_d;
  logic [N-1:0]  res_q, res_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;

  logic [N:0]    t;
  logic [N:0]    dif;
  logic          no_borrow;

  assign t = {r_q[N-1:0], q_q[N-1]};

  restador #(.W(N + 1)) u_restador (
    .minuendo     (t),
    .sustraendo   ({1'b0, d_q}),
    .diferencia   (dif),
    .cout_restador(no_borrow)
  );

  always_comb begin
    estado_d = estado_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    coc_d    = coc_q;
    res_d    = res_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (estado_q)
      IDLE: begin
        if (start) begin
          q_d   = dividendo;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(N - 1);
`ifdef DIVISOR_CERO_EN
          if (divisor == '0) begin
            estado_d = DONE;
            coc_d    = '1;
            res_d    = dividendo;
            dz_d     = 1'b1;
            done_d   = 1'b1;
          end else begin
            estado_d = RUN;
            dz_d     = 1'b0;
            busy_d   = 1'b1;
          end
`else
          estado_d = RUN;
          busy_d   = 1'b1;
`endif
        end
      end
      RUN: begin
        if (no_borrow) begin
          r_d = dif;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = t;
          q_d = {q_q[N-2:0], 1'b0};
        end
        // Results are published on entry to DONE so they are valid with the done pulse.
        if (cnt_q == '0) begin
          estado_d = DONE;
          coc_d    = q_d;
          res_d    = r_d[N-1:0];
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      coc_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      coc_q    <= coc_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign cociente   = coc_q;
  assign residuo    = res_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign div_cero   = dz_q;
  assign estado_dbg = estado_q;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial (N=4): directed cases, exhaustive sweep and random traffic
// checked every cycle against a cycle-timed arithmetic model.

module tb_divisor_secuencial;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] residuo;
  logic         busy;
  logic         done;
  logic         div_cero;
  logic [1:0]   estado_dbg;

  int checks = 0;
  int errors = 0;

`ifdef DIVISOR_CERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  divisor_secuencial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .residuo   (residuo),
    .busy      (busy),
    .done      (done),
    .div_cero  (div_cero),
    .estado_dbg(estado_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle that starts at the current posedge.
  logic [N-1:0] exp_coc = '0, exp_res = '0;
  logic         exp_busy = 0, exp_done = 0, exp_dz = 0;
  logic [N-1:0] pend_coc, pend_res;
  int           busy_left = 0;
  bit           in_done = 0;
  int           model_starts = 0;
  int           dut_dones = 0;
  bit           cmp_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_coc = '0; exp_res = '0; exp_busy = 0; exp_done = 0; exp_dz = 0;
      busy_left = 0; in_done = 0;
    end else if (in_done) begin
      in_done = 0;
      exp_done = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        exp_busy = 0; exp_done = 1; in_done = 1;
        exp_coc = pend_coc; exp_res = pend_res;
      end
    end else if (start) begin
      model_starts++;
      if (divisor == 0) begin
        pend_coc = '1;
        pend_res = dividendo;
      end else begin
        pend_coc = dividendo / divisor;
        pend_res = dividendo % divisor;
      end
      exp_dz = ZERO_EN && (divisor == 0);
      if (exp_dz) begin
        exp_done = 1; in_done = 1;
        exp_coc = pend_coc; exp_res = pend_res;
      end else begin
        busy_left = N;
        exp_busy = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("done", done, exp_done);
      check("busy", busy, exp_busy);
      check("cociente", cociente, exp_coc);
      check("residuo", residuo, exp_res);
      check("div_cero", div_cero, exp_dz);
      if (done === 1'b1) dut_dones++;
    end
  end

  // ---------------- driver ----------------
  // Returns at the negedge of the driven cycle; outputs then reflect that cycle.
  task automatic cyc(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, input logic r);
    @(negedge clk);
    start = s; dividendo = a; divisor = b; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic pin(input string name, input int coc, input int res, input int dn, input int dz);
    check({name, "_done"}, done, dn);
    check({name, "_coc"}, cociente, coc);
    check({name, "_res"}, residuo, res);
    check({name, "_dz"}, div_cero, dz);
    check({name, "_model_coc"}, exp_coc, coc);
    check({name, "_model_res"}, exp_res, res);
  endtask

  initial begin
    int dz7;
    int st0, dn0;
    rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    cmp_en = 1;
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("reset", 0, 0, 0, 0);
    check("reset_busy", busy, 0);

    // 13 / 3
    cyc(1'b1, 4'd13, 4'd3, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      check("13div3_busy", busy, 1);
      check("13div3_nodone", done, 0);
    end
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("13div3", 4, 1, 1, 0);
    idle(2);
    pin("13div3_hold", 4, 1, 0, 0);

    // 15 / 1 then 0 / 5 back-to-back
    cyc(1'b1, 4'd15, 4'd1, 1'b0);
    idle(4);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("15div1", 15, 0, 1, 0);
    cyc(1'b1, 4'd0, 4'd5, 1'b0);
    idle(4);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("0div5", 0, 0, 1, 0);
    idle(1);

    // 7 / 0
    dz7 = ZERO_EN ? 1 : 0;
    cyc(1'b1, 4'd7, 4'd0, 1'b0);
    if (ZERO_EN) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
      check("7div0_busy", busy, 0);
    end else begin
      idle(4);
      cyc(1'b0, 4'd0, 4'd0, 1'b0);
    end
    pin("7div0", 15, 7, 1, dz7);
    idle(2);

    // 9 / 4 with ignored re-pulses carrying 15 / 15
    st0 = model_starts; dn0 = dut_dones;
    cyc(1'b1, 4'd9, 4'd4, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 1'b0);
    pin("9div4", 2, 1, 1, 0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    idle(7);
    check("9div4_one_done", dut_dones - dn0, 1);
    check("9div4_one_start", model_starts - st0, 1);
    pin("9div4_hold", 2, 1, 0, 0);

    // reset during 14 / 3
    cyc(1'b1, 4'd14, 4'd3, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("abort", 0, 0, 0, 0);
    check("abort_busy", busy, 0);
    idle(3);
    cyc(1'b1, 4'd14, 4'd3, 1'b0);
    idle(4);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    pin("14div3", 4, 2, 1, 0);

    // reset and start together: start not accepted
    cyc(1'b1, 4'd5, 4'd2, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    check("rst_start_busy", busy, 0);
    idle(6);

    // exhaustive sweep
    st0 = model_starts; dn0 = dut_dones;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        cyc(1'b1, N'(a), N'(b), 1'b0);
        idle(N + 1 + $urandom_range(0, 2));
      end
    end
    check("sweep_starts", model_starts - st0, 256);
    check("sweep_dones", dut_dones - dn0, 256);

    // random traffic with sporadic resets and stray starts
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 2) == 0), N'($urandom_range(0, 15)),
          N'($urandom_range(0, 15)), 1'($urandom_range(0, 60) == 0));
    end
    idle(N + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Sequential unsigned restoring divider built around the team's ripple subtractor (`restador`, instantiated at width N+1). It produces one quotient bit per clock over N cycles, reusing a single subtractor each cycle. A start/busy/done handshake lets the lab top-level or FSM that feeds it operands sequence it. It sits beside the combinational ALU path wherever a multi-cycle divide is needed.

## Interface
- `N`, default 4: operand width in bits; N ≥ 2.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request; sampled only in IDLE.
- `dividendo`  input  N  unsigned dividend; sampled with `start`.
- `divisor`  input  N  unsigned divisor; sampled with `start`.
- `cociente`  output  N  quotient; registered.
- `residuo`  output  N  remainder; registered.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse when results become valid.
- `div_cero`  output  1  divisor was zero.
  - Only exists functionally with `DIVISOR_CERO_EN`.
  - Held until the next accepted start.

## Operation
- Internal registers:
  - `R`: N+1-bit partial remainder.
  - `Q`: N-bit shift register; initially holds the dividend, then collects quotient bits.
  - `D`: N-bit latched divisor.
  - `cnt`: ceil(log2 N)-bit counter.
- Subtractor usage: one `restador #(N+1)` computes `{R[N-1:0], Q[N-1]} - {1'b0, D}`.
  - Its `cout_restador` = 1 means no borrow (minuend ≥ subtrahend).
- FSM states and transitions:
  - IDLE, on `start`:
    - Latch Q←dividendo, D←divisor, R←0, cnt←N-1.
    - Go to RUN.
    - With `DIVISOR_CERO_EN` and divisor==0: go to DONE instead (see Configuration).
  - RUN, each cycle:
    - Form T = {R[N-1:0], Q[N-1]}.
    - If no borrow: R←T−D, Q←{Q[N-2:0],1}. Otherwise: R←T, Q←{Q[N-2:0],0}.
    - If cnt==0, go to DONE; otherwise cnt←cnt−1.
  - DONE:
    - Load cociente←Q, residuo←R[N-1:0]; assert `done`.
    - Go to IDLE unconditionally.
- `busy` is high in RUN only; `done` is high in DONE only.
- `start` is ignored in RUN and DONE; operand changes outside IDLE sampling have no effect.
- `cociente`/`residuo` hold their last values until the next DONE; they never show intermediate values.
- Arithmetic: R stays < 2·D ≤ 2^(N+1)−2, so N+1 bits never overflow. Final residuo < D fits in N bits.
- Reset (synchronous, any state including mid-RUN):
  - State←IDLE; Q, R, D, cnt ← 0.
  - cociente=0, residuo=0, busy=0, done=0, div_cero=0.
  - No done pulse for the aborted operation.

## Timing
- Cycle 0: `start` high in IDLE. Cycles 1..N: RUN (`busy`=1). Cycle N+1: DONE (`done`=1, results valid). Cycle N+2: IDLE.
- Latency from start to done is N+1 cycles. The earliest next accepted start is cycle N+2, giving a throughput of one divide per N+2 cycles.
- Zero-divisor fast path (macro on): DONE in cycle 1, latency 1, `busy` never asserts.
- `rst` and `start` high in the same cycle: reset wins, operation not accepted.

## Configuration
- Macro `DIVISOR_CERO_EN`.
- Defined:
  - A divisor of 0 at start goes IDLE→DONE directly.
  - Results: cociente=all ones, residuo=dividendo, div_cero=1.
  - div_cero clears on the next accepted start with a nonzero divisor.
- Undefined:
  - No detection; zero divisor runs the normal N-cycle RUN.
  - The algorithm naturally yields cociente=all ones and residuo=dividendo.
  - `div_cero` tied to 0.

## Test plan
All cases use N=4.
- 13÷3: start in cycle 0 → busy cycles 1–4; done in cycle 5 only; cociente=4, residuo=1, held afterward.
- 15÷1 then 0÷5 back-to-back (second start in cycle 6) → first result 15 r0 at cycle 5; second result 0 r0 at cycle 11.
- 7÷0 → with macro: done in cycle 1, cociente=15, residuo=7, div_cero=1. Without macro: done in cycle 5, same values, div_cero=0.
- 9÷4, with start re-pulsed carrying operands 15÷15 in cycles 2 and 5 → ignored; result 2 r1; no second done.
- rst asserted in cycle 3 of a 14÷3 divide → cycle 4: all outputs 0, no done. New start 14÷3 → 4 r2, done 5 cycles later.
- Exhaustive sweep of all 256 operand pairs against a reference model (÷0 per macro setting) → every result matches, done exactly once per start.
